// File: rtl/contadores_lector.sv
// Read-out requester for the pop-counter block: sweeps idx over all channels,
// samples each registered count and re-emits it as a tagged one-cycle beat.
module contadores_lector #(
  parameter int unsigned NUM_CH   = 5,
  parameter int unsigned DATA_W   = 5,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [IDX_W-1:0]  idx,
  output logic              busy,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [IDX_W-1:0]  data_idx,
  output logic              done
);

  localparam int unsigned      CNT_W    = $clog2(WAIT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(WAIT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Sweep sequencer; data_valid and done are single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      idx        <= '0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      data_idx   <= '0;
      done       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            state    <= S_WAIT;
            idx      <= '0;
            busy     <= 1'b1;
            wait_cnt <= CNT_ONE;
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_END) begin
            state <= S_SAMPLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end
        S_SAMPLE: begin
          // No timeout: retry every edge until the counter block is valid.
          if (valid_in) begin
            data_out   <= data_in;
            data_idx   <= idx;
            data_valid <= 1'b1;
            if (idx == LAST_IDX) begin
              state <= S_DONE;
            end else begin
              idx      <= idx + IDX_W'(1);
              wait_cnt <= CNT_ONE;
              state    <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_contadores_lector.sv
// Randomized self-checking bench for contadores_lector; expected beat timing
// comes from an edge-count model of the sweep rules.
module tb_contadores_lector;

  typedef struct {
    int cyc;
    int idx;
    int data;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       valid_in;
  logic [4:0] data_in_a, data_in_b;
  logic [2:0] idx_a, didx_a;
  logic [1:0] idx_b, didx_b;
  logic       busy_a, dv_a, done_a, busy_b, dv_b, done_b;
  logic [4:0] dout_a, dout_b;

  logic [4:0] counts_a[5];
  logic [4:0] counts_b[3];
  bit         vmask[256];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  beat_t qa[$], qb[$], exp_q[$];
  int    done_qa[$], done_qb[$], busy_qa[$];
  int    exp_cnt[5];
  int    exp_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter-block model: value of the selected channel, valid per edge mask.
  assign valid_in  = vmask[(cyc + 1) % 256];
  assign data_in_a = (idx_a < 3'd5) ? counts_a[idx_a] : 5'd0;
  assign data_in_b = (idx_b < 2'd3) ? counts_b[idx_b] : 5'd0;

  contadores_lector #(.NUM_CH(5), .DATA_W(5), .IDX_W(3), .WAIT_CYC(2)) dut_a (
    .clk(clk), .reset(reset), .req(req), .valid_in(valid_in), .data_in(data_in_a),
    .idx(idx_a), .busy(busy_a), .data_valid(dv_a), .data_out(dout_a),
    .data_idx(didx_a), .done(done_a));

  contadores_lector #(.NUM_CH(3), .DATA_W(5), .IDX_W(2), .WAIT_CYC(1)) dut_b (
    .clk(clk), .reset(reset), .req(req), .valid_in(valid_in), .data_in(data_in_b),
    .idx(idx_b), .busy(busy_b), .data_valid(dv_b), .data_out(dout_b),
    .data_idx(didx_b), .done(done_b));

  // Monitor: log beats and done pulses with the edge number they follow.
  always @(negedge clk) begin
    if (dv_a) qa.push_back('{cyc, int'(didx_a), int'(dout_a)});
    if (done_a) begin
      done_qa.push_back(cyc);
      busy_qa.push_back(int'(busy_a));
    end
    if (dv_b) qb.push_back('{cyc, int'(didx_b), int'(dout_b)});
    if (done_b) done_qb.push_back(cyc);
  end

  // Each channel is sampled at the first valid edge at least w+1 edges after
  // the request (or previous sample); done follows the last sample by one edge.
  function automatic void build_exp(input int t0, input int w, input int n);
    int prev;
    int e;
    prev = t0;
    for (int k = 0; k < n; k++) begin
      e = prev + w + 1;
      while (!vmask[e % 256]) e++;
      exp_q.push_back('{e, k, exp_cnt[k]});
      prev = e;
    end
    exp_done = prev + 1;
  endfunction

  task automatic clear_mon();
    qa.delete(); qb.delete(); exp_q.delete();
    done_qa.delete(); done_qb.delete(); busy_qa.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req   = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic start_req(output int t0);
    @(posedge clk); #1;
    req = 1'b1;
    @(posedge clk); #1;
    t0  = cyc;
    req = 1'b0;
  endtask

  task automatic wait_done_a(input int cnt, input int budget);
    for (int i = 0; i < budget && done_qa.size() < cnt; i++) @(posedge clk);
  endtask

  task automatic wait_done_b(input int cnt, input int budget);
    for (int i = 0; i < budget && done_qb.size() < cnt; i++) @(posedge clk);
  endtask

  task automatic set_counts_a(input int c0, input int c1, input int c2, input int c3,
                              input int c4);
    exp_cnt = '{c0, c1, c2, c3, c4};
    for (int i = 0; i < 5; i++) counts_a[i] = 5'(exp_cnt[i]);
  endtask

  task automatic test_reset();
    int t0;
    int w;
    n_tests++;
    if ({idx_a, busy_a, dv_a, dout_a, didx_a, done_a} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_init got %h want 0", {idx_a, busy_a, dv_a, dout_a, didx_a, done_a});
    end
    do_reset();
    set_counts_a(7, 9, 11, 13, 15);
    start_req(t0);
    w = $urandom_range(4, 14);
    repeat (w) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_tests++;
    if ({idx_a, busy_a, dv_a, dout_a, didx_a, done_a} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_async after %0d cyc got %h want 0", w,
               {idx_a, busy_a, dv_a, dout_a, didx_a, done_a});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({idx_a, busy_a, dout_a, didx_a} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_hold got %h want 0", {idx_a, busy_a, dout_a, didx_a});
    end
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic test_sweep();
    int t0;
    do_reset();
    set_counts_a(3, 1, 4, 1, 5);
    start_req(t0);
    wait_done_a(1, 100);
    build_exp(t0, 2, 5);
    n_tests++;
    if (qa.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL sweep_beats got %0d want %0d", qa.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < qa.size(); i++) begin
      n_tests++;
      if (qa[i].cyc != exp_q[i].cyc || qa[i].idx != exp_q[i].idx || qa[i].data != exp_q[i].data) begin
        n_fail++;
        $display("FAIL sweep_beat%0d got (%0d,%0d)@%0d want (%0d,%0d)@%0d", i, qa[i].idx,
                 qa[i].data, qa[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].cyc);
      end
    end
    n_tests++;
    if (done_qa.size() != 1 || done_qa[0] != exp_done || busy_qa[0] != 0) begin
      n_fail++;
      $display("FAIL sweep_done got n=%0d @%0d busy=%0d want @%0d busy=0", done_qa.size(),
               (done_qa.size() > 0) ? done_qa[0] : -1,
               (busy_qa.size() > 0) ? busy_qa[0] : -1, exp_done);
    end
    @(negedge clk);
    n_tests++;
    if (idx_a !== 3'd4) begin
      n_fail++;
      $display("FAIL sweep_idx_hold got %0d want 4", idx_a);
    end
  endtask

  task automatic test_stall();
    int t0;
    do_reset();
    set_counts_a($urandom_range(1, 31), $urandom_range(1, 31), $urandom_range(1, 31),
                 $urandom_range(1, 31), $urandom_range(1, 31));
    start_req(t0);
    for (int e = t0 + 9; e <= t0 + 12; e++) vmask[e % 256] = 1'b0;
    wait_done_a(1, 100);
    build_exp(t0, 2, 5);
    n_tests++;
    if (qa.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL stall_beats got %0d want %0d", qa.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < qa.size(); i++) begin
      n_tests++;
      if (qa[i].cyc != exp_q[i].cyc || qa[i].idx != exp_q[i].idx || qa[i].data != exp_q[i].data) begin
        n_fail++;
        $display("FAIL stall_beat%0d got (%0d,%0d)@%0d want (%0d,%0d)@%0d", i, qa[i].idx,
                 qa[i].data, qa[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].cyc);
      end
    end
    n_tests++;
    if (done_qa.size() != 1 || done_qa[0] != exp_done) begin
      n_fail++;
      $display("FAIL stall_done got @%0d want @%0d",
               (done_qa.size() > 0) ? done_qa[0] : -1, exp_done);
    end
    for (int i = 0; i < 256; i++) vmask[i] = 1'b1;
  endtask

  task automatic test_req_held();
    int t0;
    int t1;
    do_reset();
    set_counts_a(2, 4, 6, 8, 10);
    @(posedge clk); #1;
    req = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    wait_done_a(1, 100);
    build_exp(t0, 2, 5);
    t1 = exp_done + 1;
    build_exp(t1, 2, 5);
    wait_done_a(2, 100);
    req = 1'b0;
    n_tests++;
    if (qa.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL held_beats got %0d want %0d", qa.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < qa.size(); i++) begin
      n_tests++;
      if (qa[i].cyc != exp_q[i].cyc || qa[i].idx != exp_q[i].idx || qa[i].data != exp_q[i].data) begin
        n_fail++;
        $display("FAIL held_beat%0d got (%0d,%0d)@%0d want (%0d,%0d)@%0d", i, qa[i].idx,
                 qa[i].data, qa[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].cyc);
      end
    end
    n_tests++;
    if (done_qa.size() != 2 || done_qa[1] != exp_done) begin
      n_fail++;
      $display("FAIL held_done got n=%0d want 2 @%0d", done_qa.size(), exp_done);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    do_reset();
    set_counts_a(5, 6, 7, 8, 9);
    start_req(t0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (qa.size() != 3 || busy_a !== 1'b0 || idx_a !== 3'd0) begin
      n_fail++;
      $display("FAIL midreset got beats=%0d busy=%b idx=%0d want 3 0 0", qa.size(), busy_a, idx_a);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (30) @(posedge clk);
    n_tests++;
    if (done_qa.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_nodone got %0d pulses want 0", done_qa.size());
    end
    clear_mon();
    start_req(t0);
    wait_done_a(1, 100);
    build_exp(t0, 2, 5);
    n_tests++;
    if (qa.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL restart_beats got %0d want %0d", qa.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < qa.size(); i++) begin
      n_tests++;
      if (qa[i].cyc != exp_q[i].cyc || qa[i].idx != exp_q[i].idx || qa[i].data != exp_q[i].data) begin
        n_fail++;
        $display("FAIL restart_beat%0d got (%0d,%0d)@%0d want (%0d,%0d)@%0d", i, qa[i].idx,
                 qa[i].data, qa[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_random();
    int t0;
    for (int r = 0; r < 4; r++) begin
      clear_mon();
      for (int i = 0; i < 256; i++) vmask[i] = ($urandom_range(0, 3) != 0);
      set_counts_a($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 31));
      start_req(t0);
      wait_done_a(1, 200);
      build_exp(t0, 2, 5);
      n_tests++;
      if (qa.size() != exp_q.size() || done_qa.size() != 1 || done_qa[0] != exp_done) begin
        n_fail++;
        $display("FAIL rand%0d_sweep got beats=%0d done=%0d want %0d @%0d", r, qa.size(),
                 (done_qa.size() > 0) ? done_qa[0] : -1, exp_q.size(), exp_done);
      end
      for (int i = 0; i < exp_q.size() && i < qa.size(); i++) begin
        n_tests++;
        if (qa[i].cyc != exp_q[i].cyc || qa[i].idx != exp_q[i].idx || qa[i].data != exp_q[i].data) begin
          n_fail++;
          $display("FAIL rand%0d_beat%0d got (%0d,%0d)@%0d want (%0d,%0d)@%0d", r, i, qa[i].idx,
                   qa[i].data, qa[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].cyc);
        end
      end
      repeat (2) @(posedge clk);
    end
    for (int i = 0; i < 256; i++) vmask[i] = 1'b1;
  endtask

  task automatic test_short();
    int t0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_cnt[i]   = $urandom_range(1, 31);
      counts_b[i] = 5'(exp_cnt[i]);
    end
    start_req(t0);
    wait_done_b(1, 100);
    build_exp(t0, 1, 3);
    n_tests++;
    if (qb.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL short_beats got %0d want %0d", qb.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < qb.size(); i++) begin
      n_tests++;
      if (qb[i].cyc != exp_q[i].cyc || qb[i].idx != exp_q[i].idx || qb[i].data != exp_q[i].data) begin
        n_fail++;
        $display("FAIL short_beat%0d got (%0d,%0d)@%0d want (%0d,%0d)@%0d", i, qb[i].idx,
                 qb[i].data, qb[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].cyc);
      end
    end
    @(negedge clk);
    n_tests++;
    if (done_qb.size() != 1 || done_qb[0] != exp_done || idx_b !== 2'd2) begin
      n_fail++;
      $display("FAIL short_done got @%0d idx=%0d want @%0d idx=2",
               (done_qb.size() > 0) ? done_qb[0] : -1, idx_b, exp_done);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    for (int i = 0; i < 256; i++) vmask[i] = 1'b1;
    for (int i = 0; i < 5; i++) counts_a[i] = 5'd0;
    for (int i = 0; i < 3; i++) counts_b[i] = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_sweep();
    test_stall();
    test_req_held();
    test_reset_mid();
    test_random();
    test_short();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
